// File: rtl/scm_window_sequencer.sv
// Stream-to-window sequencer for the 2R/1W asymmetric SCM: circular-buffer writes on port a,
// overlapping ASYMM_FACTOR-word windows read on port b, advancing STRIDE words per consume.
module scm_window_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ASYMM_FACTOR = 3,
  parameter int unsigned STRIDE       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  input  logic [DATA_WIDTH-1:0]            in_data_i,
  output logic                             in_ready_o,
  output logic                             win_valid_o,
  output logic [ASYMM_FACTOR*DATA_WIDTH-1:0] win_data_o,
  input  logic                             win_ready_i,
  output logic                             scm_we_o,
  output logic [ADDR_WIDTH-1:0]            scm_waddr_o,
  output logic [DATA_WIDTH-1:0]            scm_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          scm_wbe_o,
  output logic                             scm_re_b_o,
  output logic [ADDR_WIDTH-1:0]            scm_raddr_b_o,
  input  logic [ASYMM_FACTOR*DATA_WIDTH-1:0] scm_rdata_b_i
);

  localparam int unsigned NumWords = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   NumWordsOcc = (ADDR_WIDTH + 1)'(NumWords);
  localparam logic [ADDR_WIDTH:0]   StrideOcc   = (ADDR_WIDTH + 1)'(STRIDE);
  localparam logic [ADDR_WIDTH:0]   WindowOcc   = (ADDR_WIDTH + 1)'(ASYMM_FACTOR);
  localparam logic [ADDR_WIDTH-1:0] StridePtr   = ADDR_WIDTH'(STRIDE);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic                  win_valid_q, win_valid_d;

  logic                  wr_acc;
  logic                  consumed;
  logic                  issue;
  logic [ADDR_WIDTH:0]   avail;

  assign in_ready_o  = (occ_q < NumWordsOcc) & ~flush_i;
  // Reset suppresses the write even though in_ready_o may still read high.
  assign wr_acc      = in_valid_i & in_ready_o & ~rst;
  assign consumed    = win_valid_q & win_ready_i;
  // Words of the displayed window beyond its first STRIDE remain usable by the next one.
  assign avail       = occ_q - (win_valid_q ? StrideOcc : '0);
  assign issue       = ~rst & ~flush_i & (avail >= WindowOcc) & (~win_valid_q | win_ready_i);

  assign scm_we_o      = wr_acc;
  assign scm_waddr_o   = wptr_q;
  assign scm_wdata_o   = in_data_i;
  assign scm_wbe_o     = '1;
  assign scm_re_b_o    = issue;
  assign scm_raddr_b_o = win_valid_q ? head_q + StridePtr : head_q;

  assign win_valid_o = win_valid_q;
  assign win_data_o  = scm_rdata_b_i;

  always_comb begin
    wptr_d      = wptr_q + ADDR_WIDTH'(wr_acc);
    head_d      = consumed ? head_q + StridePtr : head_q;
    occ_d       = occ_q + (ADDR_WIDTH + 1)'(wr_acc) - (consumed ? StrideOcc : '0);
    win_valid_d = issue ? 1'b1 : (consumed ? 1'b0 : win_valid_q);
    if (flush_i) begin
      wptr_d      = '0;
      head_d      = '0;
      occ_d       = '0;
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      head_q      <= '0;
      occ_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      win_valid_q <= win_valid_d;
    end
  end

endmodule

// File: tb/tb_scm_window_sequencer.sv
// Directed bench for scm_window_sequencer: two instances (STRIDE=1 and STRIDE=3), each driving
// a behavioural SCM with a registered read address and wrapping wide read.
module tb_scm_window_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        win_ready = 1'b0;

  logic        in_ready_a, win_valid_a, we_a, re_a;
  logic [95:0] win_a, rdata_a;
  logic [4:0]  waddr_a, raddr_a, rq_a;
  logic [31:0] wdata_a;
  logic [3:0]  wbe_a;
  logic [31:0] mem_a [32];

  logic        in_ready_b, win_valid_b, we_b, re_b;
  logic [95:0] win_b, rdata_b;
  logic [4:0]  waddr_b, raddr_b, rq_b;
  logic [31:0] wdata_b;
  logic [3:0]  wbe_b;
  logic [31:0] mem_b [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scm_window_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ASYMM_FACTOR(3), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_a), .win_valid_o(win_valid_a), .win_data_o(win_a),
    .win_ready_i(win_ready), .scm_we_o(we_a), .scm_waddr_o(waddr_a), .scm_wdata_o(wdata_a),
    .scm_wbe_o(wbe_a), .scm_re_b_o(re_a), .scm_raddr_b_o(raddr_a), .scm_rdata_b_i(rdata_a)
  );

  scm_window_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ASYMM_FACTOR(3), .STRIDE(3)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_b), .win_valid_o(win_valid_b), .win_data_o(win_b),
    .win_ready_i(win_ready), .scm_we_o(we_b), .scm_waddr_o(waddr_b), .scm_wdata_o(wdata_b),
    .scm_wbe_o(wbe_b), .scm_re_b_o(re_b), .scm_raddr_b_o(raddr_b), .scm_rdata_b_i(rdata_b)
  );

  // Behavioural SCMs: write lands at the edge, read address registered on re.
  always_ff @(posedge clk) begin
    if (we_a) mem_a[waddr_a] <= wdata_a;
    if (re_a) rq_a <= raddr_a;
    if (we_b) mem_b[waddr_b] <= wdata_b;
    if (re_b) rq_b <= raddr_b;
  end
  assign rdata_a = {mem_a[rq_a + 5'd2], mem_a[rq_a + 5'd1], mem_a[rq_a]};
  assign rdata_b = {mem_b[rq_b + 5'd2], mem_b[rq_b + 5'd1], mem_b[rq_b]};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [95:0] win3(input int base, input int k);
    logic [31:0] w0, w1, w2;
    w0 = 32'(base + k);
    w1 = 32'(base + k + 1);
    w2 = 32'(base + k + 2);
    return {w2, w1, w0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int k;
    bit seen31;

    // Basic
    do_reset();
    #1;
    check("rst_win_valid", win_valid_a, 0);
    check("rst_re", re_a, 0);
    check("rst_raddr", raddr_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_we", we_a, 0);
    check("wbe", wbe_a, 4'hf);
    in_valid = 1'b1; in_data = 32'hA0; #1;
    check("basic_we0", we_a, 1);
    check("basic_waddr0", waddr_a, 0);
    check("basic_wdata0", wdata_a, 32'hA0);
    tick(); in_data = 32'hA1; #1;
    check("basic_waddr1", waddr_a, 1);
    tick(); in_data = 32'hA2; #1;
    check("basic_waddr2", waddr_a, 2);
    check("basic_no_early_re", re_a, 0);
    tick(); in_valid = 1'b0; win_ready = 1'b1; #1;
    check("basic_re", re_a, 1);
    check("basic_raddr", raddr_a, 0);
    check("basic_valid_lat", win_valid_a, 0);
    tick(); in_valid = 1'b1; in_data = 32'hA3; #1;
    check("basic_valid", win_valid_a, 1);
    check("basic_win0", win_a, {32'hA2, 32'hA1, 32'hA0});
    tick(); in_valid = 1'b0; #1;
    check("basic_re2", re_a, 1);
    check("basic_raddr2", raddr_a, 1);
    tick();
    check("basic_win1", win_a, {32'hA3, 32'hA2, 32'hA1});
    check("basic_valid1", win_valid_a, 1);

    // Full and backpressure
    do_reset();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 32'(32'h100 + c); #1;
      if (we_a) acc++;
      if (c == 32) check("full_in_ready", in_ready_a, 0);
      if (c == 4) check("full_win_early", win_a, win3(32'h100, 0));
      tick();
    end
    in_valid = 1'b0; #1;
    check("full_accepted", acc, 32);
    check("full_win_held", win_a, win3(32'h100, 0));
    check("full_valid_held", win_valid_a, 1);
    check("full_no_re", re_a, 0);
    win_ready = 1'b1; #1;
    check("full_consume_re", re_a, 1);
    check("full_consume_raddr", raddr_a, 1);
    check("full_no_bypass", in_ready_a, 0);
    tick(); win_ready = 1'b0; #1;
    check("full_ready_after", in_ready_a, 1);
    check("full_valid_after", win_valid_a, 1);
    check("full_win_next", win_a, win3(32'h100, 1));

    // Wrap
    do_reset();
    win_ready = 1'b1;
    k = 0; seen31 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (c < 40); in_data = 32'(32'h200 + c); #1;
      if (win_valid_a) begin
        check("wrap_win", win_a, win3(32'h200, k));
        k++;
      end
      if (re_a && raddr_a == 5'd31) seen31 = 1'b1;
      tick();
    end
    check("wrap_count", k, 38);
    check("wrap_raddr31", seen31, 1);

    // Stride 3 (instance b)
    do_reset();
    win_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 25; c++) begin
      in_valid = (c < 9); in_data = 32'(32'h300 + c); #1;
      if (win_valid_b) begin
        check("stride_win", win_b, win3(32'h300, 3 * k));
        k++;
      end
      tick();
    end
    in_valid = 1'b0; #1;
    check("stride_count", k, 3);
    check("stride_occ", dut_b.occ_q, 0);

    // Flush
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      in_valid = (c < 5); in_data = 32'(32'h400 + c); #1;
    end
    check("flush_pre_valid", win_valid_a, 1);
    tick(); flush = 1'b1; in_valid = 1'b1; in_data = 32'h4ff; #1;
    check("flush_in_ready", in_ready_a, 0);
    check("flush_we", we_a, 0);
    check("flush_re", re_a, 0);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_valid", win_valid_a, 0);
    check("flush_ready", in_ready_a, 1);
    check("flush_occ", dut_a.occ_q, 0);
    for (int c = 0; c < 3; c++) begin
      tick(); in_valid = 1'b1; in_data = 32'(32'h500 + c); #1;
      check("flush_waddr", waddr_a, 5'(c));
    end
    tick(); in_valid = 1'b0; win_ready = 1'b1; #1;
    check("flush_re_after", re_a, 1);
    check("flush_raddr_after", raddr_a, 0);
    tick();
    check("flush_win", win_a, win3(32'h500, 0));
    check("flush_win_valid", win_valid_a, 1);

    // Reset during simultaneous write and consume
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h5ff; #1;
    check("rst_mid_we", we_a, 0);
    check("rst_mid_re", re_a, 0);
    tick(); rst = 1'b0; in_valid = 1'b0; #1;
    check("rst_mid_valid", win_valid_a, 0);
    check("rst_mid_occ", dut_a.occ_q, 0);
    check("rst_mid_ready", in_ready_a, 1);
    check("rst_mid_raddr", raddr_a, 0);
    in_valid = 1'b1; #1;
    check("rst_mid_waddr", waddr_a, 0);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
